ucode_issue: RTL and testbench

- Back-end consumer of the front-end microcode word. Sits between the decode stage's microcode ROM and the functional units (FUs).
- Buffers decoded micro-ops in a small in-order queue and tracks pending register and flag writers in a scoreboard.
- Issues the head micro-op to its FU only when no hazard exists and that FU accepts it.

---
 rtl/ucode_issue.sv | 196 +++++++++++++++++++
 tb/tb_ucode_issue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_issue.sv
// ucode_issue: in-order micro-op queue + scoreboard issue stage.
// Optional stall perf counters under `define UCODE_ISSUE_PERF_EN.
module ucode_issue #(
  parameter int UCODE_WIDTH_P   = 18,
  parameter int QUEUE_DEPTH_P   = 4,
  parameter int NUM_FU_P        = 5,
  parameter int REG_IDX_WIDTH_P = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       uop_v_i,
  input  logic [UCODE_WIDTH_P-1:0]   uop_i,
  input  logic [REG_IDX_WIDTH_P-1:0] rd_i,
  input  logic [REG_IDX_WIDTH_P-1:0] rs1_i,
  input  logic [REG_IDX_WIDTH_P-1:0] rs2_i,
  output logic                       uop_ready_o,
  input  logic                       flush_i,
  output logic                       issue_v_o,
  output logic [2:0]                 issue_fu_o,
  output logic [2:0]                 issue_op_o,
  output logic [3:0]                 issue_flags_o,
  output logic                       issue_we_o,
  output logic [4:0]                 issue_src_sel_o,
  output logic [REG_IDX_WIDTH_P-1:0] issue_rd_o,
  output logic [REG_IDX_WIDTH_P-1:0] issue_rs1_o,
  output logic [REG_IDX_WIDTH_P-1:0] issue_rs2_o,
  input  logic [NUM_FU_P-1:0]        fu_ready_i,
  input  logic                       wb_v_i,
  input  logic [REG_IDX_WIDTH_P-1:0] wb_rd_i,
  input  logic                       wb_flags_v_i,
  output logic [31:0]                stall_raw_cnt_o,
  output logic [31:0]                stall_fu_cnt_o
);

  localparam int PW = $clog2(QUEUE_DEPTH_P);
  localparam int CW = PW + 1;
  localparam int NR = 1 << REG_IDX_WIDTH_P;
  localparam logic [3:0] NFU = 4'(NUM_FU_P);

  logic [UCODE_WIDTH_P-1:0]   r_word [QUEUE_DEPTH_P];
  logic [REG_IDX_WIDTH_P-1:0] r_rd   [QUEUE_DEPTH_P];
  logic [REG_IDX_WIDTH_P-1:0] r_rs1  [QUEUE_DEPTH_P];
  logic [REG_IDX_WIDTH_P-1:0] r_rs2  [QUEUE_DEPTH_P];
  logic [PW-1:0]              r_head;
  logic [PW-1:0]              r_tail;
  logic [CW-1:0]              r_cnt;
  logic [NR-1:0]              r_sb;
  logic                       r_flags;

  logic [UCODE_WIDTH_P-1:0]   w_hw;
  logic [UCODE_WIDTH_P-1:0]   w_hw_g;
  logic [REG_IDX_WIDTH_P-1:0] w_rd;
  logic [REG_IDX_WIDTH_P-1:0] w_rs1;
  logic [REG_IDX_WIDTH_P-1:0] w_rs2;
  logic                       w_we;
  logic [2:0]                 w_op;
  logic [2:0]                 w_fu;
  logic [3:0]                 w_flg;
  logic [2:0]                 w_s2;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_nop;
  logic                       w_head_ok;
  logic [NR-1:0]              w_clr;
  logic [NR-1:0]              w_set;
  logic [NR-1:0]              w_pend;
  logic                       w_fpend;
  logic                       w_haz;
  logic                       w_fu_rdy;
  logic                       w_fire;
  logic                       w_deq;
  logic                       w_enq;
  logic                       w_unused;

  assign w_hw    = r_word[r_head];
  assign w_rd    = r_rd[r_head];
  assign w_rs1   = r_rs1[r_head];
  assign w_rs2   = r_rs2[r_head];
  assign w_we    = w_hw[17];
  assign w_op    = w_hw[16:14];
  assign w_fu    = w_hw[13:11];
  assign w_flg   = w_hw[10:7];
  assign w_s2    = w_hw[2:0];
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(QUEUE_DEPTH_P));
  assign w_unused = &{1'b0, w_hw[6:5]};

  // all-zero words and unknown FU codes are dropped silently
  assign w_nop = (w_hw == '0) | ({1'b0, w_fu} >= NFU);
  assign w_head_ok = !w_empty & !w_nop;

  // writebacks this cycle already unblock the head
  assign w_clr   = wb_v_i ? (NR'(1) << wb_rd_i) : '0;
  assign w_pend  = r_sb & ~w_clr;
  assign w_fpend = r_flags & ~wb_flags_v_i;

  assign w_haz = w_pend[w_rs1]
               | ((w_s2 == 3'd0) & w_pend[w_rs2])
               | (w_we & w_pend[w_rd])
               | ((w_fu == 3'd4) & (w_op == 3'd0) & w_fpend);

  // select ready of the head's target FU
  always_comb begin
    w_fu_rdy = 1'b0;
    for (int i = 0; i < NUM_FU_P; i++)
      if (w_fu == 3'(i)) w_fu_rdy = fu_ready_i[i];
  end

  assign issue_v_o   = w_head_ok & !w_haz & !flush_i;
  assign w_fire      = issue_v_o & w_fu_rdy;
  assign w_deq       = !flush_i & !w_empty & (w_nop | w_fire);
  assign uop_ready_o = !w_full & !flush_i;
  assign w_enq       = uop_v_i & uop_ready_o;

  assign w_hw_g          = w_empty ? '0 : w_hw;
  assign issue_we_o      = w_hw_g[17];
  assign issue_op_o      = w_hw_g[16:14];
  assign issue_fu_o      = w_hw_g[13:11];
  assign issue_flags_o   = w_hw_g[10:7];
  assign issue_src_sel_o = {w_hw_g[4:3], w_hw_g[2:0]};
  assign issue_rd_o      = w_empty ? '0 : w_rd;
  assign issue_rs1_o     = w_empty ? '0 : w_rs1;
  assign issue_rs2_o     = w_empty ? '0 : w_rs2;

  // queue storage written at the tail
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < QUEUE_DEPTH_P; i++) begin
        r_word[i] <= '0;
        r_rd[i]   <= '0;
        r_rs1[i]  <= '0;
        r_rs2[i]  <= '0;
      end
    end else if (w_enq) begin
      r_word[r_tail] <= uop_i;
      r_rd[r_tail]   <= rd_i;
      r_rs1[r_tail]  <= rs1_i;
      r_rs2[r_tail]  <= rs2_i;
    end
  end

  // pointers and occupancy; flush empties the queue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
    end
  end

  assign w_set = (w_fire & w_we) ? (NR'(1) << w_rd) : '0;

  // pending writers; a set beats a same-cycle clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sb    <= '0;
      r_flags <= 1'b0;
    end else begin
      r_sb    <= (r_sb & ~w_clr) | w_set;
      r_flags <= (r_flags & ~wb_flags_v_i) | (w_fire & (|w_flg));
    end
  end

`ifdef UCODE_ISSUE_PERF_EN
  logic [31:0] r_raw_cnt;
  logic [31:0] r_fu_cnt;

  // saturating stall counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_raw_cnt <= '0;
      r_fu_cnt  <= '0;
    end else begin
      if (w_head_ok & w_haz & (r_raw_cnt != '1))
        r_raw_cnt <= r_raw_cnt + 32'd1;
      if (issue_v_o & !w_fu_rdy & (r_fu_cnt != '1))
        r_fu_cnt <= r_fu_cnt + 32'd1;
    end
  end

  assign stall_raw_cnt_o = r_raw_cnt;
  assign stall_fu_cnt_o  = r_fu_cnt;
`else
  assign stall_raw_cnt_o = '0;
  assign stall_fu_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ucode_issue.sv
// tb_ucode_issue: directed stimulus, queue-based reference model.
// Counter checks follow `define UCODE_ISSUE_PERF_EN.
module tb_ucode_issue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uop_v = 1'b0;
  logic [17:0] uop = '0;
  logic [3:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        uop_ready;
  logic        flush = 1'b0;
  logic        issue_v;
  logic [2:0]  ifu, iop;
  logic [3:0]  iflg;
  logic        iwe;
  logic [4:0]  isrc;
  logic [3:0]  ird, irs1, irs2;
  logic [4:0]  fu_ready = '0;
  logic        wb_v = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic        wb_fv = 1'b0;
  logic [31:0] raw_cnt, fu_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ucode_issue dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .uop_v_i(uop_v), .uop_i(uop),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .uop_ready_o(uop_ready), .flush_i(flush),
    .issue_v_o(issue_v), .issue_fu_o(ifu),
    .issue_op_o(iop), .issue_flags_o(iflg),
    .issue_we_o(iwe), .issue_src_sel_o(isrc),
    .issue_rd_o(ird), .issue_rs1_o(irs1),
    .issue_rs2_o(irs2), .fu_ready_i(fu_ready),
    .wb_v_i(wb_v), .wb_rd_i(wb_rd),
    .wb_flags_v_i(wb_fv),
    .stall_raw_cnt_o(raw_cnt),
    .stall_fu_cnt_o(fu_cnt)
  );

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [17:0] mk(
    logic we, logic [2:0] op, logic [2:0] fu,
    logic [3:0] fl, logic [2:0] s2);
    return {we, op, fu, fl, 2'b00, 2'b00, s2};
  endfunction

  // reference model: queue of entries, pending sets
  typedef struct {
    logic [17:0] w;
    logic [3:0]  rd, rs1, rs2;
  } ent_t;

  ent_t        mq[$];
  bit          sb[16];
  bit          fp;
  int unsigned m_raw, m_fu;

  task automatic model_step();
    ent_t        h;
    logic [17:0] hw;
    bit          has, nop, haz, ev, erdy, fr, take;
    bit          pend[16];
    int          fi;
    has = (mq.size() != 0);
    h = '{w: 18'd0, rd: 4'd0, rs1: 4'd0, rs2: 4'd0};
    if (has) h = mq[0];
    hw = h.w;
    fi = int'(hw[13:11]);
    nop = (hw == 18'd0) || (fi >= 5);
    for (int r = 0; r < 16; r++)
      pend[r] = sb[r] && !(wb_v && int'(wb_rd) == r);
    haz = pend[h.rs1]
       || (hw[2:0] == 3'd0 && pend[h.rs2])
       || (hw[17] && pend[h.rd])
       || (fi == 4 && hw[16:14] == 3'd0 && fp && !wb_fv);
    ev = has && !nop && !haz && !flush;
    erdy = (mq.size() < 4) && !flush;
    fr = (fi < 5) ? fu_ready[fi] : 1'b0;
    chk("issue_v", 32'(issue_v), 32'(ev));
    chk("ready", 32'(uop_ready), 32'(erdy));
    chk("fu", 32'(ifu), 32'(hw[13:11]));
    chk("op", 32'(iop), 32'(hw[16:14]));
    chk("flags", 32'(iflg), 32'(hw[10:7]));
    chk("we", 32'(iwe), 32'(hw[17]));
    chk("src", 32'(isrc), 32'(hw[4:0]));
    chk("rd", 32'(ird), 32'(h.rd));
    chk("rs1", 32'(irs1), 32'(h.rs1));
    chk("rs2", 32'(irs2), 32'(h.rs2));
`ifdef UCODE_ISSUE_PERF_EN
    chk("raw_cnt", raw_cnt, m_raw);
    chk("fu_cnt", fu_cnt, m_fu);
`else
    chk("raw_cnt", raw_cnt, 32'd0);
    chk("fu_cnt", fu_cnt, 32'd0);
`endif
    if (has && !nop && haz) m_raw++;
    if (ev && !fr) m_fu++;
    if (wb_v) sb[wb_rd] = 1'b0;
    if (wb_fv) fp = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      take = has && (nop || (ev && fr));
      if (take) begin
        void'(mq.pop_front());
        if (!nop && hw[17]) sb[h.rd] = 1'b1;
        if (!nop && hw[10:7] != 4'd0) fp = 1'b1;
      end
      if (uop_v && erdy)
        mq.push_back('{w: uop, rd: rd, rs1: rs1, rs2: rs2});
    end
  endtask

  // one compare per cycle, inputs stable at negedge
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      for (int r = 0; r < 16; r++) sb[r] = 1'b0;
      fp = 1'b0;
      m_raw = 0;
      m_fu = 0;
    end else begin
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic enq(logic [17:0] w, logic [3:0] d,
                     logic [3:0] a, logic [3:0] b);
    uop_v = 1'b1;
    uop = w;
    rd = d;
    rs1 = a;
    rs2 = b;
  endtask

  task automatic wb(logic [3:0] r);
    wb_v = 1'b1;
    wb_rd = r;
    step();
    wb_v = 1'b0;
  endtask

  logic [17:0] W_ADDS, W_ANDS, W_CMP, W_BR, W_MOV, W_F7;

  initial begin
    W_ADDS = mk(1'b1, 3'd0, 3'd1, 4'hF, 3'd0);
    W_ANDS = mk(1'b1, 3'd1, 3'd1, 4'hF, 3'd0);
    W_CMP  = mk(1'b0, 3'd2, 3'd1, 4'hF, 3'd1);
    W_BR   = mk(1'b0, 3'd0, 3'd4, 4'h0, 3'd1);
    W_MOV  = mk(1'b1, 3'd2, 3'd2, 4'h0, 3'd1);
    W_F7   = mk(1'b1, 3'd1, 3'd7, 4'h1, 3'd1);

    repeat (2) @(posedge clk);
    look();
    chk("rst_ready", 32'(uop_ready), 32'd1);
    chk("rst_issue_v", 32'(issue_v), 32'd0);
    chk("rst_fu", 32'(ifu), 32'd0);
    chk("rst_raw", raw_cnt, 32'd0);
    step();
    reset_n = 1'b1;
    fu_ready = 5'h1F;
    step();

    // ADDS r2 <- r0, r1
    enq(W_ADDS, 4'd2, 4'd0, 4'd1);
    step();
    uop_v = 1'b0;
    look();
    chk("adds_v", 32'(issue_v), 32'd1);
    chk("adds_fu", 32'(ifu), 32'd1);
    step();

    // ANDS reads r2: held until writeback of r2
    enq(W_ANDS, 4'd3, 4'd2, 4'd0);
    step();
    uop_v = 1'b0;
    look();
    chk("ands_hold0", 32'(issue_v), 32'd0);
    step();
    look();
    chk("ands_hold1", 32'(issue_v), 32'd0);
    step();
    wb_v = 1'b1;
    wb_rd = 4'd2;
    look();
    chk("ands_bypass", 32'(issue_v), 32'd1);
    chk("ands_rs1", 32'(irs1), 32'd2);
    step();
    wb_v = 1'b0;
    wb(4'd3);

    // CMP then branch waiting on flags
    enq(W_CMP, 4'd0, 4'd0, 4'd2);
    step();
    enq(W_BR, 4'd0, 4'd0, 4'd0);
    step();
    uop_v = 1'b0;
    look();
    chk("br_hold0", 32'(issue_v), 32'd0);
    chk("br_fu", 32'(ifu), 32'd4);
    step();
    look();
    chk("br_hold1", 32'(issue_v), 32'd0);
    step();
    wb_fv = 1'b1;
    look();
    chk("br_go", 32'(issue_v), 32'd1);
    step();
    wb_fv = 1'b0;

    // fill with FUs stalled, then drain
    fu_ready = 5'h00;
    for (int i = 6; i < 10; i++) begin
      enq(W_MOV, 4'(i), 4'd0, 4'd0);
      step();
    end
    uop_v = 1'b0;
    look();
    chk("full_ready", 32'(uop_ready), 32'd0);
    chk("full_rd", 32'(ird), 32'd6);
    step();
    fu_ready = 5'h1F;
    look();
    chk("drain_nobyp", 32'(uop_ready), 32'd0);
    chk("drain_v", 32'(issue_v), 32'd1);
    step();
    look();
    chk("drain_ready", 32'(uop_ready), 32'd1);
    chk("drain_rd7", 32'(ird), 32'd7);
    repeat (3) step();
    for (int i = 6; i < 10; i++) wb(4'(i));

    // NOP, MOV, illegal FU
    enq(18'd0, 4'd0, 4'd0, 4'd0);
    step();
    enq(W_MOV, 4'd10, 4'd0, 4'd0);
    look();
    chk("nop_v", 32'(issue_v), 32'd0);
    step();
    enq(W_F7, 4'd11, 4'd0, 4'd0);
    look();
    chk("mov_v", 32'(issue_v), 32'd1);
    chk("mov_rd", 32'(ird), 32'd10);
    step();
    uop_v = 1'b0;
    look();
    chk("f7_v", 32'(issue_v), 32'd0);
    step();
    look();
    chk("empty_v", 32'(issue_v), 32'd0);
    step();
    wb(4'd10);

    // r5 pending, three queued, then flush
    enq(W_MOV, 4'd5, 4'd0, 4'd0);
    step();
    uop_v = 1'b0;
    step();
    fu_ready = 5'h00;
    for (int i = 12; i < 15; i++) begin
      enq(W_MOV, 4'(i), 4'd0, 4'd0);
      step();
    end
    enq(W_MOV, 4'd1, 4'd0, 4'd0);
    flush = 1'b1;
    look();
    chk("flush_ready", 32'(uop_ready), 32'd0);
    chk("flush_v", 32'(issue_v), 32'd0);
    step();
    flush = 1'b0;
    uop_v = 1'b0;
    fu_ready = 5'h1F;
    look();
    chk("post_flush_v", 32'(issue_v), 32'd0);
    chk("post_flush_rdy", 32'(uop_ready), 32'd1);
    step();
    enq(W_MOV, 4'd15, 4'd0, 4'd5);
    step();
    enq(W_MOV, 4'd4, 4'd5, 4'd0);
    look();
    chk("imm_ign_rs2", 32'(issue_v), 32'd1);
    step();
    uop_v = 1'b0;
    look();
    chk("r5_hold", 32'(issue_v), 32'd0);
    step();
    wb_v = 1'b1;
    wb_rd = 4'd5;
    look();
    chk("r5_go", 32'(issue_v), 32'd1);
    chk("r5_rs1", 32'(irs1), 32'd5);
    step();
    wb_v = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
